branch_hazard_ctrl: RTL and testbench

- Sequences ID-stage branch resolution for the 5-stage pipeline.
- Detects data hazards on branch operands and load-use hazards for ordinary instructions.
- Stalls PC and IF/ID and injects an ID/EX bubble for the required number of cycles.
- Once operands are valid, gates the ID-stage comparator's taken signal into a one-cycle IF/ID flush, and keeps saturating stall and flush event counters.

---
 rtl/branch_hazard_ctrl_pkg.sv | 14 +
 rtl/hazard_stall_calc.sv | 45 ++++
 rtl/branch_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_branch_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared pipeline definitions for ID-stage branch hazard control.
package branch_hazard_ctrl_pkg;

  localparam int unsigned REG_AW = 5;

  // Writes to register 0 are discarded, so it never creates a dependency.
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_stall_calc.sv
// Combinational stall-length calculator: how many cycles the ID instruction
// must wait before its operands (or the branch comparator's) are usable.
module hazard_stall_calc
  import branch_hazard_ctrl_pkg::*;
(
  input  logic              id_branch_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              ex_wr_en_i,
  input  logic              ex_load_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              mem_wr_en_i,
  input  logic              mem_load_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  output logic [1:0]        stall_n_o
);

  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
  logic ex_hit, mem_hit;

  assign ex_rs_hit  = id_use_rs_i & (id_rs_i == ex_rd_i) & (ex_rd_i != ZERO_REG) & ex_wr_en_i;
  assign ex_rt_hit  = id_use_rt_i & (id_rt_i == ex_rd_i) & (ex_rd_i != ZERO_REG) & ex_wr_en_i;
  assign mem_rs_hit = id_use_rs_i & (id_rs_i == mem_rd_i) & (mem_rd_i != ZERO_REG) & mem_wr_en_i;
  assign mem_rt_hit = id_use_rt_i & (id_rt_i == mem_rd_i) & (mem_rd_i != ZERO_REG) & mem_wr_en_i;

  assign ex_hit  = ex_rs_hit | ex_rt_hit;
  assign mem_hit = mem_rs_hit | mem_rt_hit;

  // Any EX hit on a branch costs at least as much as a MEM hit, so EX wins the max.
  always_comb begin
    stall_n_o = 2'd0;
    if (id_branch_i) begin
      if (ex_hit) begin
        stall_n_o = ex_load_i ? 2'd2 : 2'd1;
      end else if (mem_hit && mem_load_i) begin
        stall_n_o = 2'd1;
      end
    end else if (ex_hit && ex_load_i) begin
      stall_n_o = 2'd1;
    end
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard controller: stalls PC/IF-ID with an ID/EX bubble for
// the required cycles, then turns a taken branch into a one-cycle IF/ID flush.
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_branch_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              ex_wr_en_i,
  input  logic              ex_load_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              mem_wr_en_i,
  input  logic              mem_load_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              flush_ctrl_i,
  output logic              pc_stall_o,
  output logic              ifid_stall_o,
  output logic              idex_bubble_o,
  output logic              ifid_flush_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       remain_q, remain_d;
  logic [1:0]       stall_n;
  logic             stall_now;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  hazard_stall_calc u_calc (
    .id_branch_i (id_branch_i),
    .id_use_rs_i (id_use_rs_i),
    .id_use_rt_i (id_use_rt_i),
    .id_rs_i     (id_rs_i),
    .id_rt_i     (id_rt_i),
    .ex_wr_en_i  (ex_wr_en_i),
    .ex_load_i   (ex_load_i),
    .ex_rd_i     (ex_rd_i),
    .mem_wr_en_i (mem_wr_en_i),
    .mem_load_i  (mem_load_i),
    .mem_rd_i    (mem_rd_i),
    .stall_n_o   (stall_n)
  );

  // Next-state and control outputs; the comparator result is trusted only when
  // no stall is running or being raised this cycle.
  always_comb begin
    state_d      = state_q;
    remain_d     = remain_q;
    stall_now    = 1'b0;
    ifid_flush_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (stall_n != 2'd0) begin
          stall_now = 1'b1;
          remain_d  = stall_n - 2'd1;
          state_d   = (stall_n > 2'd1) ? ST_STALL : ST_IDLE;
        end else begin
          ifid_flush_o = id_branch_i & flush_ctrl_i;
        end
      end
      ST_STALL: begin
        stall_now = 1'b1;
        remain_d  = remain_q - 2'd1;
        if (remain_q == 2'd1) begin
          state_d = ST_IDLE;
        end
      end
    endcase
    if (rst) begin
      stall_now    = 1'b0;
      ifid_flush_o = 1'b0;
    end
    pc_stall_o    = stall_now;
    ifid_stall_o  = stall_now;
    idex_bubble_o = stall_now;
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_now && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (ifid_flush_o && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remain_q    <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: hand-written cycle table, saturation run on a
// 4-bit-counter instance, then random traffic against a behavioural model.
module tb_branch_hazard_ctrl;

  typedef struct {
    bit       rst, br, urs, urt;
    bit [4:0] rs, rt;
    bit       exw, exl;
    bit [4:0] exrd;
    bit       mw, ml;
    bit [4:0] mrd;
    bit       fc;
    bit       es, ef;
    int       sc, fcn;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       id_branch, id_use_rs, id_use_rt;
  logic [4:0] id_rs, id_rt;
  logic       ex_wr_en, ex_load;
  logic [4:0] ex_rd;
  logic       mem_wr_en, mem_load;
  logic [4:0] mem_rd;
  logic       flush_ctrl;

  logic        pc_stall, ifid_stall, idex_bubble, ifid_flush;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_stall4, ifid_stall4, idex_bubble4, ifid_flush4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int total = 0;
  int bad   = 0;

  // Model state: cycles of stall still owed, and event counts.
  int m_left, m_scnt, m_fcnt, m_scnt4, m_fcnt4;

  branch_hazard_ctrl #(.CNT_W(16)) dut (
    .clk (clk), .rst (rst),
    .id_branch_i (id_branch), .id_use_rs_i (id_use_rs), .id_use_rt_i (id_use_rt),
    .id_rs_i (id_rs), .id_rt_i (id_rt),
    .ex_wr_en_i (ex_wr_en), .ex_load_i (ex_load), .ex_rd_i (ex_rd),
    .mem_wr_en_i (mem_wr_en), .mem_load_i (mem_load), .mem_rd_i (mem_rd),
    .flush_ctrl_i (flush_ctrl),
    .pc_stall_o (pc_stall), .ifid_stall_o (ifid_stall), .idex_bubble_o (idex_bubble),
    .ifid_flush_o (ifid_flush), .stall_cnt_o (stall_cnt), .flush_cnt_o (flush_cnt)
  );

  branch_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk (clk), .rst (rst),
    .id_branch_i (id_branch), .id_use_rs_i (id_use_rs), .id_use_rt_i (id_use_rt),
    .id_rs_i (id_rs), .id_rt_i (id_rt),
    .ex_wr_en_i (ex_wr_en), .ex_load_i (ex_load), .ex_rd_i (ex_rd),
    .mem_wr_en_i (mem_wr_en), .mem_load_i (mem_load), .mem_rd_i (mem_rd),
    .flush_ctrl_i (flush_ctrl),
    .pc_stall_o (pc_stall4), .ifid_stall_o (ifid_stall4), .idex_bubble_o (idex_bubble4),
    .ifid_flush_o (ifid_flush4), .stall_cnt_o (stall_cnt4), .flush_cnt_o (flush_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit r, bit br, bit urs, bit urt, int rs, int rt,
                              bit exw, bit exl, int exrd, bit mw, bit ml, int mrd,
                              bit fc, bit es, bit ef, int sc, int fcn);
    vec_t v;
    v.rst = r; v.br = br; v.urs = urs; v.urt = urt;
    v.rs = rs[4:0]; v.rt = rt[4:0];
    v.exw = exw; v.exl = exl; v.exrd = exrd[4:0];
    v.mw = mw; v.ml = ml; v.mrd = mrd[4:0];
    v.fc = fc; v.es = es; v.ef = ef; v.sc = sc; v.fcn = fcn;
    return v;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Stall cycles the ID instruction needs, taken as the worst case over its
  // used operands from the producer rules.
  function automatic int model_n();
    int         n = 0;
    bit         used [2];
    logic [4:0] src  [2];
    used[0] = id_use_rs; used[1] = id_use_rt;
    src[0]  = id_rs;     src[1]  = id_rt;
    for (int k = 0; k < 2; k++) begin
      if (used[k] && src[k] != 5'd0) begin
        if (ex_wr_en && ex_rd == src[k]) begin
          if (id_branch) n = imax(n, ex_load ? 2 : 1);
          else if (ex_load) n = imax(n, 1);
        end
        if (mem_wr_en && mem_rd == src[k] && id_branch && mem_load) n = imax(n, 1);
      end
    end
    return n;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; id_branch = v.br; id_use_rs = v.urs; id_use_rt = v.urt;
    id_rs = v.rs; id_rt = v.rt;
    ex_wr_en = v.exw; ex_load = v.exl; ex_rd = v.exrd;
    mem_wr_en = v.mw; mem_load = v.ml; mem_rd = v.mrd;
    flush_ctrl = v.fc;
  endtask

  // One clock: drive, compare at negedge against model (and table if hand),
  // then advance the model across the posedge.
  task automatic do_cycle(input vec_t v, input bit hand);
    int n;
    bit e_stall, e_flush;
    drive(v);
    @(negedge clk);
    n = model_n();
    e_stall = 1'b0;
    e_flush = 1'b0;
    if (!v.rst) begin
      if (m_left > 0) e_stall = 1'b1;
      else if (n > 0) e_stall = 1'b1;
      else e_flush = id_branch & flush_ctrl;
    end
    chk("pc_stall", pc_stall, e_stall);
    chk("ifid_stall", ifid_stall, e_stall);
    chk("idex_bubble", idex_bubble, e_stall);
    chk("ifid_flush", ifid_flush, e_flush);
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", flush_cnt, m_fcnt);
    chk("stall_cnt4", stall_cnt4, m_scnt4);
    chk("flush_cnt4", flush_cnt4, m_fcnt4);
    chk("pc_stall4", pc_stall4, e_stall);
    chk("ifid_flush4", ifid_flush4, e_flush);
    if (hand) begin
      chk("tbl_stall", pc_stall, v.es);
      chk("tbl_flush", ifid_flush, v.ef);
      chk("tbl_stall_cnt", stall_cnt, v.sc);
      chk("tbl_flush_cnt", flush_cnt, v.fcn);
    end
    @(posedge clk);
    if (v.rst) begin
      m_left = 0; m_scnt = 0; m_fcnt = 0; m_scnt4 = 0; m_fcnt4 = 0;
    end else begin
      if (e_stall) begin
        m_left  = (m_left > 0) ? m_left - 1 : n - 1;
        m_scnt  = (m_scnt < 65535) ? m_scnt + 1 : m_scnt;
        m_scnt4 = (m_scnt4 < 15) ? m_scnt4 + 1 : m_scnt4;
      end
      if (e_flush) begin
        m_fcnt  = (m_fcnt < 65535) ? m_fcnt + 1 : m_fcnt;
        m_fcnt4 = (m_fcnt4 < 15) ? m_fcnt4 + 1 : m_fcnt4;
      end
    end
    #1;
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    drive(mk(1, 0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0));
    @(posedge clk);
    #1;
    m_left = 0; m_scnt = 0; m_fcnt = 0; m_scnt4 = 0; m_fcnt4 = 0;

    //          rst br urs urt rs rt exw exl exrd mw ml mrd fc stall flush scnt fcnt
    tbl.push_back(mk(1, 0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,0,3,0, 1,0,3, 0,0,0, 0, 1,0,0,0)); // ALU in EX: 1 stall
    tbl.push_back(mk(0, 1,1,0,3,0, 0,0,0, 1,0,3, 0, 0,0,1,0)); // forwarded from MEM
    tbl.push_back(mk(0, 1,0,1,0,7, 1,1,7, 0,0,0, 1, 1,0,1,0)); // load in EX: 2 stalls
    tbl.push_back(mk(0, 1,0,1,0,7, 0,0,0, 1,1,7, 1, 1,0,2,0)); // second stall, fc ignored
    tbl.push_back(mk(0, 1,0,1,0,7, 0,0,0, 0,0,0, 1, 0,1,3,0)); // flush after stall
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,3,1));
    tbl.push_back(mk(0, 0,1,0,4,0, 1,1,4, 0,0,0, 0, 1,0,3,1)); // load-use, non-branch
    tbl.push_back(mk(0, 0,1,0,4,0, 0,0,0, 1,1,4, 0, 0,0,4,1)); // MEM load, non-branch
    tbl.push_back(mk(0, 1,1,0,0,0, 1,1,0, 0,0,0, 1, 0,1,4,1)); // r0 load: no hazard
    tbl.push_back(mk(0, 1,1,0,0,0, 1,0,0, 0,0,0, 0, 0,0,4,2)); // r0 ALU: no hazard
    tbl.push_back(mk(0, 1,0,1,0,9, 0,0,0, 1,0,9, 1, 0,1,4,2)); // MEM ALU branch: flush
    tbl.push_back(mk(0, 1,0,1,0,7, 1,1,7, 0,0,0, 1, 1,0,4,3)); // start N=2 stall
    tbl.push_back(mk(1, 1,0,1,0,7, 1,1,7, 0,0,0, 1, 0,0,5,3)); // reset mid-stall
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0)); // no residual stall
    tbl.push_back(mk(0, 1,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0,0, 0,0,0, 0,0,0, 1, 0,0,0,0)); // non-branch fc: no flush

    foreach (tbl[i]) do_cycle(tbl[i], 1'b1);

    // Saturation: 20 back-to-back load-use stalls.
    do_cycle(mk(1, 0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0), 1'b0);
    for (int i = 0; i < 20; i++) begin
      do_cycle(mk(0, 0,1,0,4,0, 1,1,4, 0,0,0, 0, 1,0,0,0), 1'b0);
    end
    drive(mk(0, 0,0,0,0,0, 0,0,0, 0,0,0, 0, 0,0,0,0));
    @(negedge clk);
    chk("sat_stall_cnt4", stall_cnt4, 15);
    chk("stall_cnt_20", stall_cnt, 20);
    @(posedge clk);
    #1;

    // Random traffic over a small register range to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      rv = mk(($urandom_range(0, 59) == 0),
              1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom), 1'($urandom), $urandom_range(0, 3),
              1'($urandom), 1'($urandom), $urandom_range(0, 3),
              1'($urandom), 0, 0, 0, 0);
      do_cycle(rv, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
